sync_fifo_flagged: RTL and testbench
====================================

# sync_fifo_flagged

Single-clock, parametrised FIFO with a registered fill level, programmable almost-full and almost-empty thresholds, a selectable first-word-fall-through read mode, and sticky overflow/underflow error flags. It buffers data within one clock domain, for example between a protocol engine and a bit-sync'd datapath. It brings the pointer and flag scheme of the dual-clock FIFO family to same-domain use, where no Gray-code crossing is required.

## Interface
- DATA_WIDTH, 8, word width in bits
- MEM_DEPTH, 16, number of storage words; must be a power of two, at least 4
- BUS_WIDTH, 4, address width; must equal log2(MEM_DEPTH)
- AF_LEVEL, 12, W_ALMOST_FULL asserts when fill is at least AF_LEVEL (range 1..MEM_DEPTH)
- AE_LEVEL, 2, R_ALMOST_EMPTY asserts when fill is at most AE_LEVEL (range 0..MEM_DEPTH-1)
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

One clock; reset is synchronous and active-high.

- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous active-high reset
- W_INC_EN  in  1  write request
- W_DATA  in  DATA_WIDTH  write data
- R_INC_EN  in  1  read/pop request
- CLR_ERR  in  1  clears OVERFLOW and UNDERFLOW
- W_FULL  out  1  fill == MEM_DEPTH
- W_ALMOST_FULL  out  1  fill >= AF_LEVEL
- R_EMPTY  out  1  fill == 0
- R_ALMOST_EMPTY  out  1  fill <= AE_LEVEL
- R_DATA  out  DATA_WIDTH  read data
- R_VALID  out  1  R_DATA qualifier
- FILL_LEVEL  out  BUS_WIDTH+1  current word count, 0..MEM_DEPTH
- OVERFLOW  out  1  sticky: a write was rejected
- UNDERFLOW  out  1  sticky: a read was rejected

## Operation
- State consists of the write pointer, read pointer (both BUS_WIDTH bits, wrapping naturally at MEM_DEPTH), the count register (BUS_WIDTH+1 bits), the R_DATA/R_VALID registers, and the two error flags. Memory contents are not reset.
- All four level flags are decoded combinationally from the count register only. They never depend directly on same-cycle inputs.
- **Write accept:** W_INC_EN and (not W_FULL or read accepted this cycle). On accept, write memory at the write pointer and increment the write pointer. A rejected write sets OVERFLOW.
- **Read accept:** R_INC_EN and not R_EMPTY. A write in the same cycle does not rescue a read from an empty FIFO. A rejected read sets UNDERFLOW.
- **Count update:** +1 on write-only, -1 on read-only, unchanged on both or neither.
- **FWFT=0:** on read accept, R_DATA is loaded from mem[read pointer] and R_VALID is 1 on the next cycle. Otherwise R_VALID is 0 and R_DATA holds its value.
- **FWFT=1:** R_DATA = mem[read pointer] combinationally and R_VALID = not R_EMPTY. R_INC_EN pops the displayed word.
- **CLR_ERR:** clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- **RST:** has priority over all same-cycle requests, which are discarded and do not set error flags.

## Timing
- Values after reset: FILL_LEVEL=0, R_EMPTY=1, R_ALMOST_EMPTY=1, W_FULL=0, W_ALMOST_FULL=0 (AF_LEVEL≥1), R_VALID=0, R_DATA=0, OVERFLOW=0, UNDERFLOW=0.
- Flags and FILL_LEVEL reflect an accepted operation one cycle after its edge.
- Write-to-read latency into an empty FIFO:
  - FWFT=1: word visible with R_VALID=1 the cycle after the write edge.
  - FWFT=0: R_EMPTY falls the cycle after the write; a read issued then yields R_VALID one cycle later.
- Full with simultaneous read and write: both are accepted, FILL_LEVEL stays at MEM_DEPTH, and OVERFLOW is not set.
- Empty with simultaneous read and write: the write is accepted, the read is rejected, UNDERFLOW=1, and FILL_LEVEL=1.
- Pointer wrap: after MEM_DEPTH writes, the write pointer returns to 0 with no change in flag behaviour.
- Reset mid-stream: one cycle after RST, the FIFO is empty and all outputs hold their reset values.

## Test plan
- Reset, then write 1..16 on consecutive cycles (MEM_DEPTH=16) -> FILL_LEVEL counts to 16; W_ALMOST_FULL is set from the cycle after the 12th write; W_FULL is set after the 16th; a 17th write sets OVERFLOW and FILL_LEVEL stays 16.
- Drain the full FIFO with FWFT=0 -> R_DATA = 1..16 in order, each with a single-cycle R_VALID one cycle after its read; R_ALMOST_EMPTY is set once FILL_LEVEL≤2; R_EMPTY is set after the last read; an extra read sets UNDERFLOW.
- FWFT=1, single write of 0xA5 into an empty FIFO -> on the next cycle R_VALID=1 and R_DATA=0xA5 with no read; a pop returns R_EMPTY=1 on the following cycle.
- Full FIFO, simultaneous read and write of 0x3C for 20 cycles -> FILL_LEVEL=16 throughout; no OVERFLOW; data order preserved across pointer wrap.
- Empty FIFO, simultaneous read and write -> UNDERFLOW=1 and FILL_LEVEL=1; CLR_ERR on the next cycle clears UNDERFLOW; CLR_ERR together with a fresh bad read leaves UNDERFLOW=1.
- Fill to 7, assert RST for one cycle together with a write -> next cycle FILL_LEVEL=0, R_EMPTY=1, R_VALID=0, OVERFLOW=0, and the write is discarded.

Source files
------------

// File: rtl/sync_fifo_flagged_if.sv
// Handshake and status bundle for sync_fifo_flagged; clock and reset stay outside.
interface sync_fifo_flagged_if #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 4
);
   logic                  W_INC_EN;
   logic [DATA_WIDTH-1:0] W_DATA;
   logic                  R_INC_EN;
   logic                  CLR_ERR;
   logic                  W_FULL;
   logic                  W_ALMOST_FULL;
   logic                  R_EMPTY;
   logic                  R_ALMOST_EMPTY;
   logic [DATA_WIDTH-1:0] R_DATA;
   logic                  R_VALID;
   logic [BUS_WIDTH:0]    FILL_LEVEL;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output W_INC_EN, W_DATA, R_INC_EN, CLR_ERR,
      input  W_FULL, W_ALMOST_FULL, R_EMPTY, R_ALMOST_EMPTY,
             R_DATA, R_VALID, FILL_LEVEL, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  W_INC_EN, W_DATA, R_INC_EN, CLR_ERR,
      output W_FULL, W_ALMOST_FULL, R_EMPTY, R_ALMOST_EMPTY,
             R_DATA, R_VALID, FILL_LEVEL, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with registered fill count, almost-full/empty thresholds,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module sync_fifo_flagged #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 16,
   parameter int BUS_WIDTH  = 4,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 2,
   parameter bit FWFT       = 1'b0
) (
   input logic                 CLK,
   input logic                 RST,
   sync_fifo_flagged_if.slave  bus
);
   localparam logic [BUS_WIDTH:0] DEPTH_C = (BUS_WIDTH+1)'(MEM_DEPTH);
   localparam logic [BUS_WIDTH:0] AF_C    = (BUS_WIDTH+1)'(AF_LEVEL);
   localparam logic [BUS_WIDTH:0] AE_C    = (BUS_WIDTH+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic [BUS_WIDTH-1:0]  wptr_q, wptr_d;
   logic [BUS_WIDTH-1:0]  rptr_q, rptr_d;
   logic [BUS_WIDTH:0]    count_q, count_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic full, empty, rd_acc, wr_acc;

   always_comb begin
      full     = (count_q == DEPTH_C);
      empty    = (count_q == '0);
      rd_acc   = bus.R_INC_EN && !empty;
      // a same-cycle pop frees the slot, so a full FIFO still takes the write
      wr_acc   = bus.W_INC_EN && (!full || rd_acc);

      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;

      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;

      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

      if (rd_acc) begin
         rdata_d  = mem_q[rptr_q];
         rvalid_d = 1'b1;
      end

      ovf_d = (ovf_q && !bus.CLR_ERR) || (bus.W_INC_EN && !wr_acc);
      udf_d = (udf_q && !bus.CLR_ERR) || (bus.R_INC_EN && !rd_acc);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && wr_acc) mem_q[wptr_q] <= bus.W_DATA;
   end

   assign bus.W_FULL         = full;
   assign bus.W_ALMOST_FULL  = (count_q >= AF_C);
   assign bus.R_EMPTY        = empty;
   assign bus.R_ALMOST_EMPTY = (count_q <= AE_C);
   assign bus.FILL_LEVEL     = count_q;
   assign bus.OVERFLOW       = ovf_q;
   assign bus.UNDERFLOW      = udf_q;
   // fall-through output is forced to zero while empty so stale words never show
   assign bus.R_VALID        = FWFT ? !empty : rvalid_q;
   assign bus.R_DATA         = FWFT ? (empty ? '0 : mem_q[rptr_q]) : rdata_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Scoreboard bench: registered-read instance checked every cycle against a queue
// model, fall-through instance checked with a short directed sequence.
module tb_sync_fifo_flagged;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   int   n_chk = 0;
   int   n_bad = 0;

   sync_fifo_flagged_if #(.DATA_WIDTH(8), .BUS_WIDTH(4)) bus0 ();
   sync_fifo_flagged_if #(.DATA_WIDTH(8), .BUS_WIDTH(4)) bus1 ();

   sync_fifo_flagged #(.FWFT(1'b0)) u_std  (.CLK(clk), .RST(rst0), .bus(bus0));
   sync_fifo_flagged #(.FWFT(1'b1)) u_fwft (.CLK(clk), .RST(rst1), .bus(bus1));

   logic [7:0] sb_q [$];
   int         m_cnt;
   logic       m_ovf, m_udf, m_rv;
   logic [7:0] m_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock on the registered-read instance, model updated from pre-edge state
   task automatic step0(input logic w, input logic [7:0] d, input logic r,
                        input logic clr, input logic rs);
      logic full_m, empty_m, racc, wacc;
      bus0.W_INC_EN = w;
      bus0.W_DATA   = d;
      bus0.R_INC_EN = r;
      bus0.CLR_ERR  = clr;
      rst0          = rs;
      full_m  = (m_cnt == 16);
      empty_m = (m_cnt == 0);
      racc    = r && !empty_m;
      wacc    = w && (!full_m || racc);
      @(posedge clk);
      #1;
      if (rs) begin
         m_cnt = 0; sb_q.delete(); m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = 8'h00;
      end else begin
         m_rv = racc;
         if (racc) m_rd = sb_q.pop_front();
         if (wacc) sb_q.push_back(d);
         m_cnt = m_cnt + int'(wacc) - int'(racc);
         m_ovf = (m_ovf && !clr) || (w && !wacc);
         m_udf = (m_udf && !clr) || (r && !racc);
      end
      chk("fill",    32'(bus0.FILL_LEVEL),     32'(m_cnt));
      chk("full",    32'(bus0.W_FULL),         32'(m_cnt == 16));
      chk("afull",   32'(bus0.W_ALMOST_FULL),  32'(m_cnt >= 12));
      chk("empty",   32'(bus0.R_EMPTY),        32'(m_cnt == 0));
      chk("aempty",  32'(bus0.R_ALMOST_EMPTY), 32'(m_cnt <= 2));
      chk("rvalid",  32'(bus0.R_VALID),        32'(m_rv));
      chk("rdata",   32'(bus0.R_DATA),         32'(m_rd));
      chk("ovf",     32'(bus0.OVERFLOW),       32'(m_ovf));
      chk("udf",     32'(bus0.UNDERFLOW),      32'(m_udf));
   endtask

   task automatic step1(input logic w, input logic [7:0] d, input logic r, input logic rs);
      bus1.W_INC_EN = w;
      bus1.W_DATA   = d;
      bus1.R_INC_EN = r;
      bus1.CLR_ERR  = 1'b0;
      rst1          = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus0.W_INC_EN = 0; bus0.W_DATA = 0; bus0.R_INC_EN = 0; bus0.CLR_ERR = 0;
      bus1.W_INC_EN = 0; bus1.W_DATA = 0; bus1.R_INC_EN = 0; bus1.CLR_ERR = 0;
      rst0 = 1; rst1 = 1;
      m_cnt = 0; m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = 0;

      step0(0, 8'h00, 0, 0, 1);
      step0(0, 8'h00, 0, 0, 0);

      // fill to full, one overflow, then clear
      for (int i = 1; i <= 16; i++) step0(1, 8'(i), 0, 0, 0);
      step0(1, 8'h99, 0, 0, 0);
      chk("ovf_after_17", 32'(bus0.OVERFLOW), 32'd1);
      step0(0, 8'h00, 0, 1, 0);

      // drain in order, then one underflow
      for (int i = 0; i < 16; i++) step0(0, 8'h00, 1, 0, 0);
      step0(0, 8'h00, 0, 0, 0);
      step0(0, 8'h00, 1, 0, 0);
      chk("udf_after_extra", 32'(bus0.UNDERFLOW), 32'd1);
      step0(0, 8'h00, 0, 1, 0);

      // full with simultaneous read/write across pointer wrap
      for (int i = 0; i < 16; i++) step0(1, 8'(8'h40 + i), 0, 0, 0);
      for (int i = 0; i < 20; i++) step0(1, 8'h3C, 1, 0, 0);
      chk("full_rw_no_ovf", 32'(bus0.OVERFLOW), 32'd0);
      for (int i = 0; i < 16; i++) step0(0, 8'h00, 1, 0, 0);

      // empty with simultaneous read/write, clear, clear racing a new error
      step0(1, 8'h77, 1, 0, 0);
      chk("empty_rw_fill", 32'(bus0.FILL_LEVEL), 32'd1);
      step0(0, 8'h00, 0, 1, 0);
      step0(0, 8'h00, 1, 0, 0);
      step0(0, 8'h00, 1, 1, 0);
      chk("clr_vs_set", 32'(bus0.UNDERFLOW), 32'd1);
      step0(0, 8'h00, 0, 1, 0);

      // reset mid-stream discards a same-cycle write
      for (int i = 0; i < 7; i++) step0(1, 8'(8'h80 + i), 0, 0, 0);
      step0(1, 8'hEE, 0, 0, 1);
      chk("rst_fill", 32'(bus0.FILL_LEVEL), 32'd0);
      step0(0, 8'h00, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 400; i++)
         step0(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 99) == 0));

      // fall-through instance
      step1(0, 8'h00, 0, 1);
      step1(0, 8'h00, 0, 0);
      chk("fw_rst_valid", 32'(bus1.R_VALID), 32'd0);
      chk("fw_rst_empty", 32'(bus1.R_EMPTY), 32'd1);
      chk("fw_rst_data",  32'(bus1.R_DATA),  32'd0);
      step1(1, 8'hA5, 0, 0);
      chk("fw_valid",     32'(bus1.R_VALID), 32'd1);
      chk("fw_data",      32'(bus1.R_DATA),  32'hA5);
      step1(0, 8'h00, 0, 0);
      chk("fw_hold",      32'(bus1.R_DATA),  32'hA5);
      step1(0, 8'h00, 1, 0);
      chk("fw_pop_empty", 32'(bus1.R_EMPTY), 32'd1);
      chk("fw_pop_valid", 32'(bus1.R_VALID), 32'd0);
      step1(1, 8'h11, 0, 0);
      step1(1, 8'h22, 0, 0);
      chk("fw_head",      32'(bus1.R_DATA),  32'h11);
      step1(0, 8'h00, 1, 0);
      chk("fw_next",      32'(bus1.R_DATA),  32'h22);
      chk("fw_fill",      32'(bus1.FILL_LEVEL), 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
